fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues 32-bit fetches to instruction memory over a valid/ready

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, single-outstanding memory fetch, and a small
// instruction FIFO feeding decode, with flush-and-redirect on a taken branch from execute.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EXIF_branch,
  input  logic [63:0] EXIF_target,
  input  logic        IDIF_stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] IFID_instreg,
  output logic [63:0] IFID_npc,
  output logic        IFID_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [63:0]     pc_q, pc_d;
  logic [63:0]     addr_q, addr_d;
  logic            drop_q, drop_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     last_inst_q, last_inst_d;
  logic [63:0]     last_npc_q, last_npc_d;
  logic [31:0]     fifo_inst_q [DEPTH];
  logic [63:0]     fifo_npc_q  [DEPTH];

  logic            push;
  logic            pop;
  logic [63:0]     target_al;

  assign target_al = EXIF_target & ~64'h3;

  // Fetch FSM, PC/redirect bookkeeping and FIFO pointer/count update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    drop_d      = drop_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    last_inst_d = last_inst_q;
    last_npc_d  = last_npc_q;
    push        = 1'b0;
    pop         = (count_q != CW'(0)) && !IDIF_stall && !EXIF_branch;

    unique case (state_q)
      S_IDLE: begin
        if (EXIF_branch) begin
          pc_d = target_al;
        end else if (count_q < CW'(DEPTH)) begin
          state_d = S_REQ;
          addr_d  = pc_q;
        end
      end
      S_REQ: begin
        // A redirect never alters a request already on the bus; its response is marked for discard.
        if (EXIF_branch) begin
          pc_d   = target_al;
          drop_d = 1'b1;
        end
        if (mem_req_ready) begin
          state_d = S_WAIT;
          if (!EXIF_branch && !drop_q) pc_d = pc_q + 64'd4;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (EXIF_branch) pc_d = target_al;
          else if (!drop_q) push = 1'b1;
        end else if (EXIF_branch) begin
          pc_d   = target_al;
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (EXIF_branch) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + AW'(1);
        last_inst_d = fifo_inst_q[rd_ptr_q];
        last_npc_d  = fifo_npc_q[rd_ptr_q];
      end
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= '0;
      drop_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_inst_q <= '0;
      last_npc_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_npc_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      drop_q      <= drop_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_inst_q <= last_inst_d;
      last_npc_q  <= last_npc_d;
      if (push) begin
        fifo_inst_q[wr_ptr_q] <= mem_resp_data;
        fifo_npc_q[wr_ptr_q]  <= addr_q + 64'd4;
      end
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = addr_q;

  // Head of FIFO when non-empty, otherwise the most recently popped entry.
  assign IFID_ready   = (count_q != CW'(0));
  assign IFID_instreg = IFID_ready ? fifo_inst_q[rd_ptr_q] : last_inst_q;
  assign IFID_npc     = IFID_ready ? fifo_npc_q[rd_ptr_q]  : last_npc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: bench-side memory model plus an in-order decode scoreboard.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EXIF_branch;
  logic [63:0] EXIF_target;
  logic        IDIF_stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] IFID_instreg;
  logic [63:0] IFID_npc;
  logic        IFID_ready;

  fetch_stage #(.RESET_PC(64'h1000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .EXIF_branch(EXIF_branch), .EXIF_target(EXIF_target), .IDIF_stall(IDIF_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .IFID_instreg(IFID_instreg), .IFID_npc(IFID_npc), .IFID_ready(IFID_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          pending = 1'b0;
  int          cnt = 0;
  int          lat = 1;
  logic [63:0] paddr = '0;
  bit          sb_en = 1'b0;
  bit          ca_en = 1'b0;
  logic [63:0] exp_npc = '0;
  logic [63:0] exp_addr = '0;
  logic [63:0] hold_addr;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard pops and accepted addresses before the edge, update memory model after.
  task automatic step();
    logic        rv, rr, rsp, pop;
    logic [63:0] a;
    rv  = mem_req_valid;
    rr  = mem_req_ready;
    a   = mem_addr;
    rsp = mem_resp_valid;
    pop = reset && IFID_ready && !IDIF_stall && !EXIF_branch;
    if (sb_en && pop) begin
      chk("sb_npc", IFID_npc, exp_npc);
      chk("sb_inst", 64'(IFID_instreg), 64'(mdata(exp_npc - 64'd4)));
      exp_npc = exp_npc + 64'd4;
    end
    if (ca_en && reset && rv && rr) begin
      chk("req_addr", a, exp_addr);
      exp_addr = exp_addr + 64'd4;
    end
    @(posedge clk);
    #1;
    if (rsp) pending = 1'b0;
    else if (pending && cnt > 0) cnt--;
    if (reset && rv && rr) begin
      pending = 1'b1;
      paddr   = a;
      cnt     = lat - 1;
    end
    mem_resp_valid = pending && (cnt == 0);
    mem_resp_data  = pending ? mdata(paddr) : 32'h0;
  endtask

  initial begin
    reset          = 1'b1;
    EXIF_branch    = 1'b0;
    EXIF_target    = '0;
    IDIF_stall     = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_ready", 64'(IFID_ready), 64'd0);
    chk("rst_inst", 64'(IFID_instreg), 64'd0);
    chk("rst_npc", IFID_npc, 64'd0);
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    exp_addr = 64'h1000;
    exp_npc  = 64'h1004;
    sb_en    = 1'b1;
    ca_en    = 1'b1;

    // 1: one-cycle memory, free-running decode
    step();
    chk("t1_first_valid", 64'(mem_req_valid), 64'd1);
    chk("t1_first_addr", mem_addr, 64'h1000);
    step();
    step();
    chk("t1_ready", 64'(IFID_ready), 64'd1);
    chk("t1_npc", IFID_npc, 64'h1004);
    chk("t1_inst", 64'(IFID_instreg), 64'(mdata(64'h1000)));
    repeat (12) step();

    // 2: decode stall fills FIFO and stops fetching
    IDIF_stall = 1'b1;
    repeat (8) step();
    hold_addr = exp_npc;
    chk("t2_ready", 64'(IFID_ready), 64'd1);
    chk("t2_head", IFID_npc, hold_addr);
    chk("t2_no_req", 64'(mem_req_valid), 64'd0);
    repeat (2) begin
      step();
      chk("t2_head_hold", IFID_npc, hold_addr);
      chk("t2_no_req_hold", 64'(mem_req_valid), 64'd0);
    end
    IDIF_stall = 1'b0;
    repeat (10) step();

    // 3: memory back-pressure keeps the request stable
    mem_req_ready = 1'b0;
    for (int i = 0; i < 20 && !mem_req_valid; i++) step();
    chk("t3_req_seen", 64'(mem_req_valid), 64'd1);
    chk("t3_addr", mem_addr, exp_addr);
    hold_addr = exp_addr;
    repeat (3) begin
      step();
      chk("t3_valid_hold", 64'(mem_req_valid), 64'd1);
      chk("t3_addr_hold", mem_addr, hold_addr);
    end
    mem_req_ready = 1'b1;
    step();
    chk("t3_accepted", 64'(mem_req_valid), 64'd0);

    // 4: redirect while a 3-cycle fetch is outstanding
    lat = 3;
    for (int i = 0; i < 30 && !(pending && !mem_resp_valid); i++) step();
    chk("t4_in_wait", 64'(pending && !mem_resp_valid), 64'd1);
    EXIF_target = 64'h2002;
    EXIF_branch = 1'b1;
    step();
    EXIF_branch = 1'b0;
    chk("t4_flushed", 64'(IFID_ready), 64'd0);
    exp_npc  = 64'h2004;
    exp_addr = 64'h2000;
    for (int i = 0; i < 30 && !mem_req_valid; i++) step();
    chk("t4_new_addr", mem_addr, 64'h2000);
    for (int i = 0; i < 30 && !IFID_ready; i++) step();
    chk("t4_npc", IFID_npc, 64'h2004);
    chk("t4_inst", 64'(IFID_instreg), 64'(mdata(64'h2000)));

    // 5: branch coincides with a response while decode stalls
    lat = 2;
    for (int i = 0; i < 30 && !mem_resp_valid; i++) step();
    step();
    IDIF_stall = 1'b1;
    for (int i = 0; i < 30 && !mem_resp_valid; i++) step();
    chk("t5_resp_seen", 64'(mem_resp_valid), 64'd1);
    chk("t5_fifo_busy", 64'(IFID_ready), 64'd1);
    EXIF_target = 64'h3000;
    EXIF_branch = 1'b1;
    step();
    EXIF_branch = 1'b0;
    IDIF_stall  = 1'b0;
    chk("t5_flushed", 64'(IFID_ready), 64'd0);
    exp_npc  = 64'h3004;
    exp_addr = 64'h3000;
    for (int i = 0; i < 30 && !IFID_ready; i++) step();
    chk("t5_npc", IFID_npc, 64'h3004);

    // 6: asynchronous reset in the middle of a fetch
    lat = 3;
    IDIF_stall = 1'b1;
    for (int i = 0; i < 30 && !(IFID_ready && pending && !mem_resp_valid); i++) step();
    chk("t6_setup", 64'(IFID_ready && pending && !mem_resp_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_req_valid", 64'(mem_req_valid), 64'd0);
    chk("t6_ready", 64'(IFID_ready), 64'd0);
    chk("t6_npc", IFID_npc, 64'd0);
    chk("t6_addr", mem_addr, 64'd0);
    pending        = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    IDIF_stall     = 1'b0;
    lat            = 1;
    exp_addr       = 64'h1000;
    exp_npc        = 64'h1004;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step();
    chk("t6_first_valid", 64'(mem_req_valid), 64'd1);
    chk("t6_first_addr", mem_addr, 64'h1000);
    for (int i = 0; i < 30 && !IFID_ready; i++) step();
    chk("t6_npc_after", IFID_npc, 64'h1004);
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
